// File: rtl/vga_grid_renderer.sv
// Purpose : VGA timing generator plus ROWS x COLS battleship grid renderer with a player-turn banner.
// Latency : 2 clocks from counter value to colour/sync/frame_start outputs (all aligned).
// Backpressure: none; free-running pixel stream, board inputs snapshotted once per frame.
//
// Ports:
//   clock50      pixel clock
//   reset        synchronous, active-high
//   board_state  2 bits per cell, cell (r,c) at [2*(r*COLS+c) +: 2]
//   player_turn  0 = player 1 (blue banner), 1 = player 2 (red banner)
//   vga_red/green/blue  3-bit colour levels, zero during blanking
//   vga_hor_sync/vga_ver_sync  sync pulses, active level = SYNC_POS
//   frame_start  one-clock pulse when outputs show pixel (0,0)
// Optional macro GRIDLINE_EN: draws dark-grey cell borders over the grid.
module vga_grid_renderer #(
  parameter int H_DISP   = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_DISP   = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter int SYNC_POS = 1,
  parameter int ROWS     = 10,
  parameter int COLS     = 10,
  parameter int CELL     = 48,
  parameter int BANNER_H = 96,
  parameter int BOARD_X0 = 160,
  parameter int BOARD_Y0 = 96
) (
  input  logic                     clock50,
  input  logic                     reset,
  input  logic [2*ROWS*COLS-1:0]   board_state,
  input  logic                     player_turn,
  output logic [2:0]               vga_red,
  output logic [2:0]               vga_green,
  output logic [2:0]               vga_blue,
  output logic                     vga_hor_sync,
  output logic                     vga_ver_sync,
  output logic                     frame_start
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  // Bits needed to address one bit of the flattened board vector.
  localparam int IW      = $clog2(2 * ROWS * COLS);

  localparam logic [10:0] L_H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] L_V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] L_H_DISP   = 11'(H_DISP);
  localparam logic [10:0] L_V_DISP   = 11'(V_DISP);
  localparam logic [10:0] L_HS_BEG   = 11'(H_DISP + H_FP);
  localparam logic [10:0] L_HS_END   = 11'(H_DISP + H_FP + H_SYNC);
  localparam logic [10:0] L_VS_BEG   = 11'(V_DISP + V_FP);
  localparam logic [10:0] L_VS_END   = 11'(V_DISP + V_FP + V_SYNC);
  localparam logic [10:0] L_GX0      = 11'(BOARD_X0);
  localparam logic [10:0] L_GX1      = 11'(BOARD_X0 + COLS * CELL);
  localparam logic [10:0] L_GY0      = 11'(BOARD_Y0);
  localparam logic [10:0] L_GY1      = 11'(BOARD_Y0 + ROWS * CELL);
  localparam logic [10:0] L_BANNER   = 11'(BANNER_H);
  localparam logic [10:0] L_CELL_LST = 11'(CELL - 1);
  localparam logic [10:0] L_COL_LST  = 11'(COLS - 1);
  localparam logic [10:0] L_ROW_LST  = 11'(ROWS - 1);
  localparam logic [IW-2:0] L_COLS_I = (IW-1)'(COLS);
  localparam logic        L_SON      = (SYNC_POS != 0);

  localparam logic [8:0] C_BLUE  = 9'b000_000_111;
  localparam logic [8:0] C_RED   = 9'b111_000_000;
  localparam logic [8:0] C_GREY  = 9'b100_100_100;
  localparam logic [8:0] C_WHITE = 9'b111_111_111;
  localparam logic [8:0] C_DGREY = 9'b011_011_011;

  logic [10:0] r_h_cnt, r_v_cnt;
  logic [10:0] r_col, r_xoff, r_row, r_yoff;
  logic [IW-2:0] r_row_base;              // row * COLS, kept incrementally
  logic [2*ROWS*COLS-1:0] r_shadow_board;
  logic        r_shadow_turn;

  logic [10:0] w_h_next, w_v_next;
  logic        w_h_wrap;

  assign w_h_wrap = (r_h_cnt == L_H_LAST);
  assign w_h_next = w_h_wrap ? 11'd0 : r_h_cnt + 11'd1;
  assign w_v_next = !w_h_wrap ? r_v_cnt :
                    (r_v_cnt == L_V_LAST) ? 11'd0 : r_v_cnt + 11'd1;

  // Counters, cell sub-counters and frame snapshot. Sub-counters hold the
  // cell position of the current r_h_cnt/r_v_cnt; they restart one clock
  // ahead so they read zero exactly on the grid's first column/line, and
  // saturate on the last row/column so the board index never runs out of range.
  always_ff @(posedge clock50) begin
    if (reset) begin
      r_h_cnt        <= '0;
      r_v_cnt        <= '0;
      r_col          <= '0;
      r_xoff         <= '0;
      r_row          <= '0;
      r_yoff         <= '0;
      r_row_base     <= '0;
      r_shadow_board <= '0;
      r_shadow_turn  <= 1'b0;
    end else begin
      r_h_cnt <= w_h_next;
      r_v_cnt <= w_v_next;

      if (w_h_next == L_GX0) begin
        r_col  <= '0;
        r_xoff <= '0;
      end else if (r_xoff == L_CELL_LST) begin
        r_xoff <= '0;
        if (r_col != L_COL_LST) r_col <= r_col + 11'd1;
      end else begin
        r_xoff <= r_xoff + 11'd1;
      end

      if (w_h_wrap) begin
        if (w_v_next == L_GY0) begin
          r_row      <= '0;
          r_yoff     <= '0;
          r_row_base <= '0;
        end else if (r_yoff == L_CELL_LST) begin
          r_yoff <= '0;
          if (r_row != L_ROW_LST) begin
            r_row      <= r_row + 11'd1;
            r_row_base <= r_row_base + L_COLS_I;
          end
        end else begin
          r_yoff <= r_yoff + 11'd1;
        end
      end

      // Capture on the last clock of the frame so the whole next frame
      // renders from one consistent board.
      if (w_h_wrap && (r_v_cnt == L_V_LAST)) begin
        r_shadow_board <= board_state;
        r_shadow_turn  <= player_turn;
      end
    end
  end

  logic          w_active, w_in_grid, w_gline;
  logic [IW-2:0] w_idx;
  logic [IW-1:0] w_bitsel;
  logic [1:0]    w_code;
  logic [8:0]    w_pix;
  logic          w_hs, w_vs, w_fs;

  assign w_active  = (r_h_cnt < L_H_DISP) && (r_v_cnt < L_V_DISP);
  assign w_in_grid = (r_h_cnt >= L_GX0) && (r_h_cnt < L_GX1) &&
                     (r_v_cnt >= L_GY0) && (r_v_cnt < L_GY1);
  assign w_idx     = r_row_base + (IW-1)'(r_col);
  assign w_bitsel  = {w_idx, 1'b0};
  assign w_code    = r_shadow_board[w_bitsel +: 2];

`ifdef GRIDLINE_EN
  logic w_in_ext;
  // Extended box includes one extra column/line to close the right and bottom edges.
  assign w_in_ext = (r_h_cnt >= L_GX0) && (r_h_cnt <= L_GX1) &&
                    (r_v_cnt >= L_GY0) && (r_v_cnt <= L_GY1);
  assign w_gline  = w_in_ext && ((r_xoff == 11'd0) || (r_h_cnt == L_GX1) ||
                                 (r_yoff == 11'd0) || (r_v_cnt == L_GY1));
`else
  assign w_gline  = 1'b0;
`endif

  always_comb begin
    w_pix = 9'd0;
    if (w_active) begin
      if (w_gline) begin
        w_pix = C_DGREY;
      end else if (w_in_grid) begin
        case (w_code)
          2'b00:   w_pix = C_BLUE;
          2'b01:   w_pix = C_GREY;
          2'b10:   w_pix = C_WHITE;
          default: w_pix = C_RED;
        endcase
      end else if (r_v_cnt < L_BANNER) begin
        w_pix = r_shadow_turn ? C_RED : C_BLUE;
      end
    end
  end

  assign w_hs = ((r_h_cnt >= L_HS_BEG) && (r_h_cnt < L_HS_END)) ? L_SON : ~L_SON;
  assign w_vs = ((r_v_cnt >= L_VS_BEG) && (r_v_cnt < L_VS_END)) ? L_SON : ~L_SON;
  assign w_fs = (r_h_cnt == 11'd0) && (r_v_cnt == 11'd0);

  logic [8:0] r1_pix, r2_pix;
  logic       r1_hs, r1_vs, r1_fs, r2_hs, r2_vs, r2_fs;

  // Two matched stages keep colour, sync and frame_start aligned.
  always_ff @(posedge clock50) begin
    if (reset) begin
      r1_pix <= '0;
      r1_hs  <= ~L_SON;
      r1_vs  <= ~L_SON;
      r1_fs  <= 1'b0;
      r2_pix <= '0;
      r2_hs  <= ~L_SON;
      r2_vs  <= ~L_SON;
      r2_fs  <= 1'b0;
    end else begin
      r1_pix <= w_pix;
      r1_hs  <= w_hs;
      r1_vs  <= w_vs;
      r1_fs  <= w_fs;
      r2_pix <= r1_pix;
      r2_hs  <= r1_hs;
      r2_vs  <= r1_vs;
      r2_fs  <= r1_fs;
    end
  end

  assign vga_red      = r2_pix[8:6];
  assign vga_green    = r2_pix[5:3];
  assign vga_blue     = r2_pix[2:0];
  assign vga_hor_sync = r2_hs;
  assign vga_ver_sync = r2_vs;
  assign frame_start  = r2_fs;

endmodule

// File: tb/tb_vga_grid_renderer.sv
// Testbench for vga_grid_renderer using a reduced timing (56 x 35 clocks per frame)
// and a 3 x 4 grid of 4-pixel cells at (8,8). Expected pixels are queued by the
// stimulus and checked by a monitor that tracks the output pixel position.
module tb_vga_grid_renderer;

  localparam int HT    = 56;   // 40 + 4 + 8 + 4
  localparam int VT    = 35;   // 30 + 1 + 2 + 2
  localparam int FRAME = 1960; // 56 * 35

`ifdef GRIDLINE_EN
  localparam bit GLEN = 1'b1;
`else
  localparam bit GLEN = 1'b0;
`endif

  localparam logic [8:0] C_BLK   = 9'b000_000_000;
  localparam logic [8:0] C_BLUE  = 9'b000_000_111;
  localparam logic [8:0] C_RED   = 9'b111_000_000;
  localparam logic [8:0] C_GREY  = 9'b100_100_100;
  localparam logic [8:0] C_WHITE = 9'b111_111_111;
  localparam logic [8:0] C_DGREY = 9'b011_011_011;

  logic        clock50 = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] board_state = '0;
  logic        player_turn = 1'b0;
  logic [2:0]  vga_red, vga_green, vga_blue;
  logic        vga_hor_sync, vga_ver_sync, frame_start;

  always #5 clock50 = ~clock50;

  vga_grid_renderer #(
    .H_DISP(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_DISP(30), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_POS(1), .ROWS(3), .COLS(4), .CELL(4),
    .BANNER_H(6), .BOARD_X0(8), .BOARD_Y0(8)
  ) dut (
    .clock50(clock50),
    .reset(reset),
    .board_state(board_state),
    .player_turn(player_turn),
    .vga_red(vga_red),
    .vga_green(vga_green),
    .vga_blue(vga_blue),
    .vga_hor_sync(vga_hor_sync),
    .vga_ver_sync(vga_ver_sync),
    .frame_start(frame_start)
  );

  typedef struct {
    int         f;
    int         x;
    int         y;
    logic [8:0] col;
    int         id;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   pos = -2;   // output pixel index since reset release; <0 = not yet valid

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at pos %0d: got %h want %h", nm, pos, got, want);
    end
  endtask

  task automatic push(input int f, input int x, input int y,
                      input logic [8:0] col, input bit gl, input int id);
    exp_t e;
    e.f   = f;
    e.x   = x;
    e.y   = y;
    e.col = (GLEN && gl) ? C_DGREY : col;
    e.id  = id;
    sb_q.push_back(e);
  endtask

  // Monitor: positions are derived from the reset release, not from DUT outputs.
  initial begin
    logic       rs;
    logic [8:0] pix;
    int         f, x, y;
    exp_t       e;
    forever begin
      @(posedge clock50);
      rs = reset;
      @(negedge clock50);
      if (rs) pos = -2;
      else    pos = pos + 1;
      pix = {vga_red, vga_green, vga_blue};
      if (pos < 0) begin
        chk("rst_rgb", 32'(pix), 32'd0);
        chk("rst_hs", 32'(vga_hor_sync), 32'd0);
        chk("rst_vs", 32'(vga_ver_sync), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
      end else begin
        f = pos / FRAME;
        x = pos % HT;
        y = (pos / HT) % VT;
        chk("frame_start", 32'(frame_start), 32'((pos % FRAME) == 0));
        chk("hsync", 32'(vga_hor_sync), 32'((x >= 44) && (x < 52)));
        chk("vsync", 32'(vga_ver_sync), 32'((y >= 31) && (y < 33)));
        if (x >= 40 || y >= 30) chk("blank", 32'(pix), 32'd0);
        if (sb_q.size() > 0 && sb_q[0].f == f && sb_q[0].x == x && sb_q[0].y == y) begin
          e = sb_q.pop_front();
          chk($sformatf("pixel#%0d(%0d,%0d)", e.id, x, y), 32'(pix), 32'(e.col));
        end
      end
    end
  end

  task automatic wait_pos(input int target);
    int n = 0;
    while (pos < target && n < 6000) begin
      @(posedge clock50);
      n++;
    end
    if (pos < target) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_timeout: pos %0d required %0d", pos, target);
    end
  endtask

  initial begin
    int n;
    reset       = 1'b1;
    board_state = '0;
    player_turn = 1'b1;
    repeat (3) @(posedge clock50);
    #1 reset = 1'b0;

    // Frame 0 renders the reset shadow: water, player 1 (blue banner).
    push(0,  2,  2, C_BLUE,  1'b0,  1);
    push(0,  9,  9, C_BLUE,  1'b0,  2);
    // Frame 1: snapshot turn=1, all water.
    push(1,  0,  2, C_RED,   1'b0,  3);
    push(1, 39,  2, C_RED,   1'b0,  4);
    push(1, 40,  2, C_BLK,   1'b0,  5);
    push(1, 55,  2, C_BLK,   1'b0,  6);
    push(1,  9,  9, C_BLUE,  1'b0,  7);
    push(1,  2, 10, C_BLK,   1'b0,  8);
    push(1, 30, 15, C_BLK,   1'b0,  9);
    push(1, 21, 17, C_BLUE,  1'b0, 10);  // board changes at line 15: must not show yet
    push(1, 10, 25, C_BLK,   1'b0, 11);

    wait_pos(FRAME + 15 * HT + 10);
    board_state         = '0;
    board_state[1:0]    = 2'b11;  // cell (0,0) hit
    board_state[11:10]  = 2'b01;  // cell (1,1) ship
    board_state[23:22]  = 2'b10;  // cell (2,3) miss
    push(2,  2,  3, C_RED,   1'b0, 12);
    push(2, 30,  5, C_RED,   1'b0, 13);  // turn changes at line 1: still red
    push(2,  8,  8, C_RED,   1'b1, 14);
    push(2, 12,  8, C_BLUE,  1'b1, 15);
    push(2,  9,  9, C_RED,   1'b0, 16);
    push(2, 13,  9, C_BLUE,  1'b0, 17);
    push(2, 12, 10, C_BLUE,  1'b1, 18);
    push(2, 13, 10, C_BLUE,  1'b0, 19);
    push(2, 25, 10, C_BLK,   1'b0, 20);
    push(2, 11, 11, C_RED,   1'b0, 21);
    push(2, 13, 13, C_GREY,  1'b0, 22);
    push(2, 17, 13, C_BLUE,  1'b0, 23);
    push(2, 21, 17, C_WHITE, 1'b0, 24);
    push(2, 23, 19, C_WHITE, 1'b0, 25);
    push(2, 24, 19, C_BLK,   1'b1, 26);
    push(2,  9, 20, C_BLK,   1'b1, 27);

    wait_pos(2 * FRAME + 1 * HT + 5);
    player_turn = 1'b0;
    push(3, 30,  5, C_BLUE,  1'b0, 28);
    push(3,  9,  9, C_RED,   1'b0, 29);

    // Mid-frame reset, then the first frame restarts from the reset shadow.
    wait_pos(3 * FRAME + 15 * HT + 20);
    chk("sb_pre_reset", 32'(sb_q.size()), 32'd0);
    reset = 1'b1;
    repeat (3) @(posedge clock50);
    #1 reset = 1'b0;
    push(0,  9,  9, C_BLUE,  1'b0, 30);
    push(1, 30,  5, C_BLUE,  1'b0, 31);
    push(1,  9,  9, C_RED,   1'b0, 32);

    n = 0;
    while (sb_q.size() != 0 && n < 6000) begin
      @(posedge clock50);
      n++;
    end
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    repeat (4) @(posedge clock50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
